alu_divider: RTL

//  Multi-cycle iterative divider: the inverse companion to the single-cycle ALU MUL path.

---
 rtl/alu_divider_pkg.sv | 21 ++
 rtl/alu_divider_div_step.sv | 30 +++
 rtl/alu_divider.sv | 138 +++++++++++++
 3 files changed

// File: rtl/alu_divider_pkg.sv
// Shared types and constants for the iterative divider.
package alu_divider_pkg;

  // Divider FSM encodings
  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_PREP  = 2'd1,
    DIV_CALC  = 2'd2,
    DIV_FIXUP = 2'd3
  } div_state_e;

  // Execute-stage opcodes that route to this unit
  localparam logic [5:0] OP_DIV  = 6'h1A;
  localparam logic [5:0] OP_DIVU = 6'h1B;

  // Two's-complement magnitude of a value when it is treated as signed
  function automatic logic [63:0] mag64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/alu_divider_div_step.sv
// One radix-2 restoring division iteration, purely combinational.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // Shift in the next dividend bit, try the subtraction, keep it when it does not borrow.
  // rem < divisor holds on entry, so a valid trial always fits in WIDTH bits and the
  // top bit of trial is a clean borrow indicator.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    trial  = rem_sh - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/alu_divider.sv
// Multi-cycle radix-2 restoring divider (DIV / DIVU) beside the execute-stage ALU.
module alu_divider
  import alu_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             vout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;       // operands as issued
  logic             sgn_q;
  logic [WIDTH-1:0] rem_q, quo_q;   // {rem,quo} shift pair; quo starts as |dividend|
  logic [WIDTH-1:0] dvs_q;          // |divisor|
  logic             q_neg, r_neg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic             a_neg, b_neg, b_zero;

  assign a_neg  = sgn_q & a_q[WIDTH-1];
  assign b_neg  = sgn_q & b_q[WIDTH-1];
  assign b_zero = (b_q == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  // State register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= DIV_IDLE;
    else          state <= state_nxt;
  end

  // Next-state: divide-by-zero skips the iteration entirely
  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE:  if (start) state_nxt = DIV_PREP;
      DIV_PREP:  state_nxt = b_zero ? DIV_FIXUP : DIV_CALC;
      DIV_CALC:  if (cnt == LAST_CNT) state_nxt = DIV_FIXUP;
      DIV_FIXUP: state_nxt = DIV_IDLE;
      default:   state_nxt = DIV_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state != DIV_IDLE);
  end

  // Operand capture, sign stripping and the per-bit iteration
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            a_q   <= din_a;
            b_q   <= din_b;
            sgn_q <= signed_op;
          end
        end
        DIV_PREP: begin
          // MIN negates to itself, which reads correctly as an unsigned magnitude
          quo_q <= a_neg ? (~a_q + 1'b1) : a_q;
          dvs_q <= b_neg ? (~b_q + 1'b1) : b_q;
          rem_q <= '0;
          cnt   <= '0;
          q_neg <= a_neg ^ b_neg;
          r_neg <= a_neg;
        end
        DIV_CALC: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt   <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result registers: written only in FIXUP, held otherwise; done is a one-cycle pulse
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      vout      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == DIV_FIXUP) begin
        done <= 1'b1;
        if (b_zero) begin
          quotient  <= '1;
          remainder <= a_q;
          div_zero  <= 1'b1;
          vout      <= 1'b0;
        end else begin
          // MIN / -1 already yields quotient=MIN, remainder=0 here; only the flag is extra
          quotient  <= q_neg ? (~quo_q + 1'b1) : quo_q;
          remainder <= r_neg ? (~rem_q + 1'b1) : rem_q;
          div_zero  <= 1'b0;
          vout      <= sgn_q && (a_q == MIN_VAL) && (b_q == '1);
        end
      end
    end
  end

endmodule
